ama_riscv_hazard_ctrl: RTL

AMA_RISCV_HAZARD_CTRL -- requirements
Module: ama_riscv_hazard_ctrl

---
 rtl/ama_riscv_hazard_ctrl.sv | 232 +++++++++++++++++++++++
 1 files changed

// File: rtl/ama_riscv_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ama_riscv_hazard_ctrl
//
// Hazard controller for an in-order RISC-V pipeline. It chooses the forwarding
// source for each ID-stage register operand. It detects load-use hazards and
// stalls for them. It also holds the pipeline while a data-memory access is
// outstanding, and clears IF after a taken branch or jump.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   rs_id           ID source register indices, source i at [5i+4:5i]
//   rs_used_id      source i is actually read by the ID instruction
//   rd_stg          destination index per downstream stage, stage k at
//                   [5(k-1)+4:5(k-1)], stage 1 = EX
//   reg_we_stg      stage k writes the register file
//   load_stg        stage k holds a load
//   redirect        taken branch / jump resolved in EX
//   dmem_req        MEM-stage data-memory access this cycle
//   dmem_ready      data memory completes this cycle
//   fwd_sel         per-source select, 0 = register file, k = stage k
//   stall_*         hold the corresponding stage register
//   clear_*         insert a bubble into the corresponding stage
//   pc_we           PC write enable
//   state           RUN=0, LU_STALL=1, MEM_WAIT=2, FLUSH=3
//   stall_cycles    saturating count of cycles with pc_we=0 since reset
// ---------------------------------------------------------------------------
module ama_riscv_hazard_ctrl #(
    parameter int  NUM_SRC    = 2,
    parameter int  FWD_STAGES = 2,
    parameter int  LOAD_LAT   = 1,
    parameter int  FLUSH_CYC  = 1,
    localparam int SELW       = $clog2(FWD_STAGES + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5*NUM_SRC-1:0]      rs_id,
    input  logic [NUM_SRC-1:0]        rs_used_id,
    input  logic [5*FWD_STAGES-1:0]   rd_stg,
    input  logic [FWD_STAGES-1:0]     reg_we_stg,
    input  logic [FWD_STAGES-1:0]     load_stg,
    input  logic                      redirect,
    input  logic                      dmem_req,
    input  logic                      dmem_ready,
    output logic [SELW*NUM_SRC-1:0]   fwd_sel,
    output logic                      stall_if,
    output logic                      stall_id,
    output logic                      stall_ex,
    output logic                      stall_mem,
    output logic                      clear_if,
    output logic                      clear_id,
    output logic                      clear_ex,
    output logic                      pc_we,
    output logic [1:0]                state,
    output logic [15:0]               stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2,
        FLUSH    = 2'd3
    } state_t;

    state_t                    state_q;
    logic [2:0]                cnt;
    logic [SELW*NUM_SRC-1:0]   fwd_sel_raw;
    logic                      lu_hazard;
    logic [2:0]                lu_len;
    logic                      mem_block;

    assign mem_block = dmem_req && !dmem_ready;
    assign state     = state_q;

    // Forwarding and load-use detection. The stages are scanned from oldest
    // to youngest, so the youngest matching stage wins because it holds the
    // newest value. Only that winning stage decides whether the operand is
    // still an in-flight load. The stall length is the worst case over all
    // sources.
    always_comb begin
        int   best_k;
        logic best_ld;
        fwd_sel_raw = '0;
        lu_hazard   = 1'b0;
        lu_len      = 3'd0;
        best_k      = 0;
        best_ld     = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            best_k  = 0;
            best_ld = 1'b0;
            for (int k = FWD_STAGES - 1; k >= 0; k--) begin
                if (rs_used_id[i] && reg_we_stg[k] &&
                    (rd_stg[5*k +: 5] != 5'd0) &&
                    (rd_stg[5*k +: 5] == rs_id[5*i +: 5])) begin
                    best_k  = k + 1;
                    best_ld = load_stg[k];
                end
            end
            fwd_sel_raw[SELW*i +: SELW] = SELW'(best_k);
            if ((best_k != 0) && best_ld && (best_k <= LOAD_LAT)) begin
                lu_hazard = 1'b1;
                if (3'(LOAD_LAT - best_k + 1) > lu_len) begin
                    lu_len = 3'(LOAD_LAT - best_k + 1);
                end
            end
        end
    end

    // Control FSM. The RUN cycle that detects a load-use hazard is already
    // the first stall cycle. LU_STALL therefore covers only the cycles that
    // remain, and a one-cycle stall never leaves RUN. The redirect cycle
    // itself clears IF, so FLUSH lasts FLUSH_CYC-1 further cycles. A
    // redirect seen while in LU_STALL is dropped, because EX holds a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt     <= 3'd0;
        end else begin
            case (state_q)
                RUN: begin
                    if (mem_block) begin
                        state_q <= MEM_WAIT;
                    end else if (redirect) begin
                        if (FLUSH_CYC > 1) begin
                            state_q <= FLUSH;
                            cnt     <= 3'(FLUSH_CYC - 1);
                        end
                    end else if (lu_hazard && (lu_len > 3'd1)) begin
                        state_q <= LU_STALL;
                        cnt     <= lu_len - 3'd1;
                    end
                end
                LU_STALL: begin
                    if (mem_block) begin
                        state_q <= MEM_WAIT;
                        cnt     <= 3'd0;
                    end else if (cnt <= 3'd1) begin
                        state_q <= RUN;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state_q <= RUN;
                    end
                end
                FLUSH: begin
                    if (mem_block) begin
                        state_q <= MEM_WAIT;
                        cnt     <= 3'd0;
                    end else if (cnt <= 3'd1) begin
                        state_q <= RUN;
                        cnt     <= 3'd0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                default: begin
                    state_q <= RUN;
                    cnt     <= 3'd0;
                end
            endcase
        end
    end

    // Output decode. These outputs are combinational so that a hazard or a
    // redirect acts in the cycle it is seen. While reset is held, every
    // stage is cleared and the PC is frozen.
    always_comb begin
        fwd_sel   = fwd_sel_raw;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        stall_ex  = 1'b0;
        stall_mem = 1'b0;
        clear_if  = 1'b0;
        clear_id  = 1'b0;
        clear_ex  = 1'b0;
        pc_we     = 1'b1;
        if (rst) begin
            fwd_sel  = '0;
            clear_if = 1'b1;
            clear_id = 1'b1;
            clear_ex = 1'b1;
            pc_we    = 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (redirect) begin
                        clear_if = 1'b1;
                        clear_id = 1'b1;
                    end else if (!mem_block && lu_hazard) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        clear_ex = 1'b1;
                        pc_we    = 1'b0;
                    end
                end
                LU_STALL: begin
                    stall_if = 1'b1;
                    stall_id = 1'b1;
                    clear_ex = 1'b1;
                    pc_we    = 1'b0;
                end
                MEM_WAIT: begin
                    stall_if  = 1'b1;
                    stall_id  = 1'b1;
                    stall_ex  = 1'b1;
                    stall_mem = 1'b1;
                    pc_we     = 1'b0;
                end
                FLUSH: begin
                    clear_if = 1'b1;
                end
                default: begin
                    pc_we = 1'b1;
                end
            endcase
        end
    end

    // Stall statistics. The counter counts every cycle in which the PC is
    // frozen outside reset, and it holds at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= 16'd0;
        end else if (!pc_we && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end

endmodule
